// File: rtl/game_round_sequencer_if.sv
// game_round_sequencer_if: control, display and capture signals of the round sequencer
interface game_round_sequencer_if;
    logic       start;
    logic [2:0] level;
    logic       cap_valid;
    logic [2:0] cap_data;
    logic       cap_en;
    logic       cap_clear;
    logic       show_valid;
    logic [2:0] show_idx;
    logic       busy;
    logic       round_pass;
    logic       round_fail;
    logic [7:0] score;
    modport master (
        output start, level, cap_valid, cap_data,
        input  cap_en, cap_clear, show_valid, show_idx, busy, round_pass, round_fail, score
    );
    modport slave (
        input  start, level, cap_valid, cap_data,
        output cap_en, cap_clear, show_valid, show_idx, busy, round_pass, round_fail, score
    );
endinterface

// File: rtl/game_round_sequencer.sv
// game_round_sequencer: generates, shows and checks a random button pattern per round
module game_round_sequencer #(
    parameter int          SHOW_ON_CYC  = 4,
    parameter int          SHOW_OFF_CYC = 2,
    parameter int          TIMEOUT_CYC  = 64,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input logic                   clk,
    input logic                   rst,
    game_round_sequencer_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + SHOW_ON_CYC + SHOW_OFF_CYC + 1);
    typedef enum logic [2:0] {IDLE, GEN, SHOW_ON, SHOW_OFF, INPUT, PASS, FAIL} state_t;
    state_t        state_q, state_d;
    logic [15:0]   lfsr_q;
    logic [3:0]    k_q, k_d, len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    score_q;
    logic          clr_q;
    logic [2:0]    pat_q [16];
    logic [1:0]    lvl;
    assign lvl = (!bus.level[2] && bus.level[1:0] != 2'd0) ? bus.level[1:0] : 2'd1;
    // state, counters, LFSR, score and the cap_clear entry pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            k_q     <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            score_q <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            k_q     <= k_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            score_q <= (state_q == PASS && score_q != 8'hFF) ? score_q + 8'd1 : score_q;
            clr_q   <= state_d == INPUT && state_q != INPUT;
        end
    end
    // pattern memory is written only while generating and never cleared
    always_ff @(posedge clk) begin
        if (state_q == GEN) pat_q[k_q] <= lfsr_q[2:0];
    end
    // next-state logic; cnt times the show phases and the input timeout
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        len_d   = len_q;
        cnt_d   = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d = GEN;
                    k_d     = '0;
                    len_d   = {lvl, 2'b11};
                end
            end
            GEN: begin
                cnt_d = '0;
                k_d   = k_q + 4'd1;
                if (k_q == len_q - 4'd1) begin
                    state_d = SHOW_ON;
                    k_d     = '0;
                end
            end
            SHOW_ON: begin
                if (cnt_q == CW'(SHOW_ON_CYC - 1)) begin
                    state_d = SHOW_OFF;
                    cnt_d   = '0;
                end
            end
            SHOW_OFF: begin
                if (cnt_q == CW'(SHOW_OFF_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = (k_q == len_q - 4'd1) ? INPUT : SHOW_ON;
                    k_d     = (k_q == len_q - 4'd1) ? 4'd0 : k_q + 4'd1;
                end
            end
            INPUT: begin
                if (bus.cap_valid) begin
                    cnt_d = '0;
                    if (bus.cap_data != pat_q[k_q]) state_d = FAIL;
                    else if (k_q == len_q - 4'd1) state_d = PASS;
                    else k_d = k_q + 4'd1;
                end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    state_d = FAIL;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.cap_en     = state_q == INPUT;
    assign bus.cap_clear  = clr_q;
    assign bus.show_valid = state_q == SHOW_ON;
    assign bus.show_idx   = (state_q == SHOW_ON) ? pat_q[k_q] : 3'd0;
    assign bus.busy       = state_q != IDLE;
    assign bus.round_pass = state_q == PASS;
    assign bus.round_fail = state_q == FAIL;
    assign bus.score      = score_q;
endmodule
